// File: rtl/motor_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : motor_cmd_pkg
//  Purpose  : Shared types and constants for the motor command framer.
//             Holds the framer state enum, the default frame header byte and
//             a helper that returns the frame length in bytes.
//  Config   : MOTOR_CMD_CHKSUM_EN - when defined, frames carry a trailing
//             checksum byte, and frame_len() includes it.
//  Revision : 1.0 - initial release
// ============================================================================
package motor_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_CH_ID  = 3'd2,
        ST_CH_VAL = 3'd3,
        ST_CSUM   = 3'd4
    } frame_state_t;

    localparam logic [7:0] c_default_header = 8'hA5;

    // Total bytes in one frame: header, an (id, value) pair per channel and,
    // when enabled, the checksum byte.
    function automatic int unsigned frame_len(input int unsigned num_ch);
`ifdef MOTOR_CMD_CHKSUM_EN
        return 2 + 2 * num_ch;
`else
        return 1 + 2 * num_ch;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module   : sync_edge_detect
//  Purpose  : Brings an asynchronous level into the clk domain with a 2-flop
//             synchroniser and produces a one-cycle pulse on its rising edge.
//  Ports    : clk      - rising-edge clock
//             reset_n  - asynchronous active-low reset
//             async_in - asynchronous input level
//             rise     - one-cycle pulse per synchronised 0->1 transition
//  Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rise = r_sync & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/motor_cmd_framer.sv
`default_nettype none
// ============================================================================
//  Module   : motor_cmd_framer
//  Purpose  : Serialises a snapshot of all motor channel states into a byte
//             frame for a UART transmitter:
//               HEADER, {ch_id, ch_value} x NUM_CH [, checksum]
//             A frame is triggered by a send_req press or by motor_state
//             differing from the last snapshot sent. Triggers arriving while
//             a frame is in flight coalesce into one back-to-back frame.
//  Config   : MOTOR_CMD_CHKSUM_EN - when defined, a modulo-256 checksum of
//             every byte after the header is appended.
//  Ports    : clk         - rising-edge clock
//             reset_n     - asynchronous active-low reset
//             motor_state - NUM_CH packed channel states, ch0 in the LSBs
//             send_req    - asynchronous push-button level
//             tx_data     - byte to the UART
//             tx_valid    - tx_data valid
//             tx_ready    - UART accepts the byte this cycle
//             busy        - frame in progress
//             frame_cnt   - completed frames, wraps at 16 bits
//  Revision : 1.0 - initial release
// ============================================================================
module motor_cmd_framer
    import motor_cmd_pkg::*;
#(
    parameter int         NUM_CH  = 4,
    parameter int         STATE_W = 5,
    parameter logic [7:0] HEADER  = c_default_header
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_CH*STATE_W-1:0]  motor_state,
    input  logic                       send_req,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic [15:0]                frame_cnt
);

    frame_state_t              r_state;
    logic [NUM_CH*STATE_W-1:0] r_snap;
    logic [NUM_CH*STATE_W-1:0] r_last;
    logic [3:0]                r_ch;
    logic [7:0]                r_csum;
    logic                      r_pending;
    logic [7:0]                r_tx_data;
    logic                      r_tx_valid;
    logic [15:0]               r_frame_cnt;

    logic                      w_send_rise;
    logic                      w_busy;
    logic [NUM_CH*STATE_W-1:0] w_ref;
    logic                      w_trigger;
    logic                      w_accept;
    logic                      w_last_ch;
    logic                      w_final;
    logic [7:0]                w_ch_val;
    logic [7:0]                w_csum_next;

    sync_edge_detect u_send_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (send_req),
        .rise     (w_send_rise)
    );

    assign w_busy = (r_state != ST_IDLE);

    // While a frame is in flight its snapshot is what will become the
    // last-sent value, so compare against it; otherwise a change that the
    // current frame already carries would queue a redundant repeat frame.
    assign w_ref       = w_busy ? r_snap : r_last;
    assign w_trigger   = w_send_rise | (motor_state != w_ref);
    assign w_accept    = r_tx_valid & tx_ready;
    assign w_last_ch   = (r_ch == 4'(NUM_CH - 1));
    assign w_csum_next = r_csum + r_tx_data;

`ifdef MOTOR_CMD_CHKSUM_EN
    assign w_final = (r_state == ST_CSUM);
`else
    assign w_final = (r_state == ST_CH_VAL) && w_last_ch;
`endif

    always_comb begin
        w_ch_val              = '0;
        w_ch_val[STATE_W-1:0] = r_snap[r_ch*STATE_W +: STATE_W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_snap      <= '0;
            r_last      <= '0;
            r_ch        <= '0;
            r_csum      <= '0;
            r_pending   <= 1'b0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_snap     <= motor_state;
                        r_state    <= ST_HDR;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= HEADER;
                        r_csum     <= '0;
                        r_ch       <= '0;
                    end
                end
                default: begin
                    if (w_accept && w_final) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_last      <= r_snap;
                        // A trigger in the final cycle is folded in here so
                        // it is not lost between pending and the restart.
                        if (r_pending || w_trigger) begin
                            r_pending <= 1'b0;
                            r_snap    <= motor_state;
                            r_state   <= ST_HDR;
                            r_tx_data <= HEADER;
                            r_csum    <= '0;
                            r_ch      <= '0;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_tx_valid <= 1'b0;
                            r_tx_data  <= '0;
                        end
                    end else begin
                        if (w_trigger) begin
                            r_pending <= 1'b1;
                        end
                        if (w_accept) begin
                            case (r_state)
                                ST_HDR: begin
                                    r_state   <= ST_CH_ID;
                                    r_tx_data <= {4'd0, r_ch};
                                end
                                ST_CH_ID: begin
                                    r_state   <= ST_CH_VAL;
                                    r_tx_data <= w_ch_val;
                                    r_csum    <= w_csum_next;
                                end
                                ST_CH_VAL: begin
                                    r_csum    <= w_csum_next;
                                    r_state   <= ST_CH_ID;
                                    r_ch      <= r_ch + 4'd1;
                                    r_tx_data <= {4'd0, r_ch + 4'd1};
`ifdef MOTOR_CMD_CHKSUM_EN
                                    if (w_last_ch) begin
                                        r_state   <= ST_CSUM;
                                        r_tx_data <= w_csum_next;
                                    end
`endif
                                end
                                default: begin
                                    r_state    <= ST_IDLE;
                                    r_tx_valid <= 1'b0;
                                    r_tx_data  <= '0;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign busy      = w_busy;
    assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: doc/motor_cmd_framer.md
MOTOR_CMD_FRAMER -- requirements
Module: motor_cmd_framer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of motor channels (1..16).
REQ-002 SHALL have parameter STATE_W, default 5, bits per channel state (1..8).
REQ-003 SHALL have parameter HEADER, default 8'hA5, frame start byte.
REQ-004 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port motor_state  input  NUM_CH*STATE_W  channel states; ch0 in the LSBs.
REQ-007 SHALL have port send_req  input  1  asynchronous push-button level, active-high.
REQ-008 SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-009 SHALL have port tx_valid  output  1  tx_data valid.
REQ-010 SHALL have port tx_ready  input  1  UART ready to accept a byte.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port frame_cnt  output  16  count of completed frames.

Function
REQ-013 SHALL pass send_req through a 2-flop synchroniser and a rising-edge detector; one press gives one trigger.
REQ-014 SHALL raise a trigger on a send_req edge or when motor_state differs from the last-sent snapshot.
REQ-015 SHALL, on a trigger in IDLE, latch motor_state into a snapshot and enter HDR on the next cycle.
REQ-016 SHALL sequence states IDLE -> HDR -> CH_ID -> CH_VAL -> (CH_ID for next channel | CSUM after the last channel) -> IDLE.
REQ-017 SHALL drive tx_data = HEADER in HDR, channel index in CH_ID, zero-extended snapshot state in CH_VAL, and checksum in CSUM.
REQ-018 SHALL compute checksum as the 8-bit modulo-256 sum of all bytes after the header.
REQ-019 SHALL advance a byte only on a cycle with tx_valid && tx_ready; tx_data SHALL hold stable while tx_valid && !tx_ready.
REQ-020 SHALL assert tx_valid in every state except IDLE.
REQ-021 SHALL ignore motor_state changes during a frame for the frame content, because the frame uses the snapshot.
REQ-022 SHALL, on a trigger during a frame, set one pending flag; further triggers SHALL coalesce into it.
REQ-023 SHALL, on leaving CSUM with pending set, clear pending and start a new frame without an IDLE cycle, re-latching the snapshot.
REQ-024 SHALL update the last-sent snapshot when the frame's final byte is accepted.
REQ-025 SHALL increment frame_cnt by 1 when the final byte is accepted, wrapping 16'hFFFF -> 0.
REQ-026 SHALL drive busy = (state != IDLE).

Reset
REQ-027 SHALL, while reset_n=0, force state=IDLE, tx_valid=0, tx_data=0, busy=0, frame_cnt=0, pending=0, synchroniser flops=0, and snapshots=0.
REQ-028 SHALL abandon a partial frame on reset mid-frame; no further bytes of that frame SHALL be sent.
REQ-029 SHALL send a frame on the first cycle after reset release if motor_state is nonzero, via the change rule.

Configuration
REQ-030 SHALL, with MOTOR_CMD_CHKSUM_EN defined, include the CSUM state and send the checksum byte; frame length = 2 + 2*NUM_CH bytes.
REQ-031 SHALL, without MOTOR_CMD_CHKSUM_EN, omit CSUM and end the frame after the last CH_VAL; frame length = 1 + 2*NUM_CH bytes.

Structure
REQ-032 SHALL place the state enum type, the default HEADER constant, and the frame-length function in package motor_cmd_pkg.
REQ-033 SHALL implement synchroniser and edge detection as sub-module sync_edge_detect, instanced once.

Verification (NUM_CH=4, STATE_W=5, checksum enabled)
REQ-034 SHALL check that motor_state = {5'd3,5'd2,5'd1,5'd0} from reset with tx_ready tied to 1 gives bytes A5 00 00 01 01 02 02 03 03 0C and frame_cnt=1.
REQ-035 SHALL check that tx_ready low for 5 cycles during a CH_VAL byte keeps tx_data/tx_valid stable, then the frame completes with an identical byte stream.
REQ-036 SHALL check that three send_req pulses during one frame give exactly one back-to-back extra frame and frame_cnt=2.
REQ-037 SHALL check that a motor_state change mid-frame leaves the current frame unchanged and the following frame carries the new values.
REQ-038 SHALL check that reset_n pulsed low after the third byte gives tx_valid=0 immediately, frame_cnt=0, and no remaining bytes.
REQ-039 SHALL check that frame_cnt preset by forcing to FFFF, then one frame completed, gives frame_cnt=0000.
